// File: rtl/usbspi_host.sv
// rtl/usbspi_host.sv - SPI host that serialises 32-bit register read/write commands into mode-0 frames
module usbspi_host #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 8
) (
    input  logic        up_clk,
    input  logic        up_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wr_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_rd_data,
    output logic        busy,
    output logic        spi_cs,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [6:0]  bit_q, bit_d;
    logic [7:0]  gap_q, gap_d;
    logic        wr_q, wr_d;
    logic [79:0] shreg_q, shreg_d;
    logic [31:0] rx_q, rx_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        sclk_q, sclk_d;
    logic        cs_q, cs_d;
    logic        mosi_q, mosi_d;

    logic [79:0] frame;
    logic [6:0]  last_bit;

    // Writes are padded to 80 bits so one shift register serves both frame types.
    assign frame    = cmd_wr ? {8'h01, cmd_addr, cmd_wr_data, 8'h00} : {8'h02, cmd_addr, 40'h0};
    assign last_bit = wr_q ? 7'd71 : 7'd79;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        gap_d       = gap_q;
        wr_d        = wr_q;
        shreg_d     = shreg_q;
        rx_d        = rx_q;
        rd_data_d   = rd_data_q;
        rsp_valid_d = 1'b0;
        sclk_d      = sclk_q;
        cs_d        = cs_q;
        mosi_d      = mosi_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_SHIFT;
                    wr_d    = cmd_wr;
                    mosi_d  = frame[79];
                    shreg_d = {frame[78:0], 1'b0};
                    cs_d    = 1'b0;
                    div_d   = 8'd0;
                    bit_d   = 7'd0;
                end
            end
            S_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = 8'd0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // End of the high half: sample MISO, then present the next MOSI bit.
                        sclk_d  = 1'b0;
                        rx_d    = {rx_q[30:0], spi_miso};
                        mosi_d  = shreg_q[79];
                        shreg_d = {shreg_q[78:0], 1'b0};
                        if (bit_q == last_bit) begin
                            state_d = S_HOLD;
                        end else begin
                            bit_d = bit_q + 7'd1;
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (div_q == DIV_LAST) begin
                    state_d     = S_GAP;
                    div_d       = 8'd0;
                    gap_d       = 8'd0;
                    cs_d        = 1'b1;
                    rsp_valid_d = 1'b1;
                    rd_data_d   = wr_q ? 32'h0 : rx_q;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge up_clk or posedge up_rst) begin
        if (up_rst) begin
            state_q     <= S_IDLE;
            div_q       <= 8'd0;
            bit_q       <= 7'd0;
            gap_q       <= 8'd0;
            wr_q        <= 1'b0;
            shreg_q     <= 80'h0;
            rx_q        <= 32'h0;
            rd_data_q   <= 32'h0;
            rsp_valid_q <= 1'b0;
            sclk_q      <= 1'b0;
            cs_q        <= 1'b1;
            mosi_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            gap_q       <= gap_d;
            wr_q        <= wr_d;
            shreg_q     <= shreg_d;
            rx_q        <= rx_d;
            rd_data_q   <= rd_data_d;
            rsp_valid_q <= rsp_valid_d;
            sclk_q      <= sclk_d;
            cs_q        <= cs_d;
            mosi_q      <= mosi_d;
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rd_data = rd_data_q;
    assign spi_cs      = cs_q;
    assign spi_clk     = sclk_q;
    assign spi_mosi    = mosi_q;

endmodule

// File: tb/tb_usbspi_host.sv
// tb/tb_usbspi_host.sv - randomized self-checking bench for usbspi_host with a mode-0 target model
module tb_usbspi_host;

    logic        up_clk;
    logic        up_rst;
    logic        cmd_valid   [2];
    logic        cmd_ready   [2];
    logic        cmd_wr      [2];
    logic [31:0] cmd_addr    [2];
    logic [31:0] cmd_wr_data [2];
    logic        rsp_valid   [2];
    logic [31:0] rsp_rd_data [2];
    logic        busy        [2];
    logic        spi_cs      [2];
    logic        spi_clk     [2];
    logic        spi_mosi    [2];
    logic        spi_miso    [2];

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;

    // Per-instance target/monitor state; only the monitor process writes these.
    logic [79:0] tx         [2];
    logic [79:0] mosi_cap   [2];
    logic [79:0] frame_last [2];
    logic [79:0] frame_prev [2];
    logic [31:0] rsp_last   [2];
    int edges_total [2];
    int cs_low_total[2];
    int rsp_total   [2];
    int acc_total   [2];
    int acc_cyc     [2];
    int acc_prev    [2];
    int last_rise   [2];
    int bit_idx     [2];
    int period_bad  [2];
    int mosi_bad    [2];
    logic prev_cs   [2];
    logic prev_clk  [2];
    logic prev_mosi [2];
    int div_of      [2] = '{4, 1};

    usbspi_host #(.CLK_DIV(4), .CS_GAP(8)) u_dut0 (
        .up_clk(up_clk), .up_rst(up_rst),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_wr(cmd_wr[0]),
        .cmd_addr(cmd_addr[0]), .cmd_wr_data(cmd_wr_data[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rd_data(rsp_rd_data[0]), .busy(busy[0]),
        .spi_cs(spi_cs[0]), .spi_clk(spi_clk[0]), .spi_mosi(spi_mosi[0]), .spi_miso(spi_miso[0])
    );

    usbspi_host #(.CLK_DIV(1), .CS_GAP(1)) u_dut1 (
        .up_clk(up_clk), .up_rst(up_rst),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_wr(cmd_wr[1]),
        .cmd_addr(cmd_addr[1]), .cmd_wr_data(cmd_wr_data[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rd_data(rsp_rd_data[1]), .busy(busy[1]),
        .spi_cs(spi_cs[1]), .spi_clk(spi_clk[1]), .spi_mosi(spi_mosi[1]), .spi_miso(spi_miso[1])
    );

    initial begin
        up_clk = 1'b0;
        forever #5 up_clk = ~up_clk;
    end

    initial forever begin
        @(posedge up_clk);
        cyc = cyc + 1;
    end

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        chk_cnt = chk_cnt + 1;
        if (got === exp) pass_cnt = pass_cnt + 1;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Target model and bus monitor, sampled on the falling edge of up_clk.
    initial begin
        for (int g = 0; g < 2; g++) begin
            mosi_cap[g] = '0; frame_last[g] = '0; frame_prev[g] = '0; rsp_last[g] = '0;
            edges_total[g] = 0; cs_low_total[g] = 0; rsp_total[g] = 0; acc_total[g] = 0;
            acc_cyc[g] = 0; acc_prev[g] = 0; last_rise[g] = -1; bit_idx[g] = 0;
            period_bad[g] = 0; mosi_bad[g] = 0;
            prev_cs[g] = 1'b1; prev_clk[g] = 1'b0; prev_mosi[g] = 1'b0; spi_miso[g] = 1'b0;
        end
        forever begin
            @(negedge up_clk);
            for (int g = 0; g < 2; g++) begin
                if (!spi_cs[g] && prev_cs[g]) begin
                    bit_idx[g]   = 0;
                    spi_miso[g]  = tx[g][79];
                    last_rise[g] = -1;
                end
                if (!spi_cs[g]) cs_low_total[g] = cs_low_total[g] + 1;
                if (spi_cs[g] && !prev_cs[g]) begin
                    frame_prev[g] = frame_last[g];
                    frame_last[g] = mosi_cap[g];
                end
                if (!spi_cs[g] && spi_clk[g] && !prev_clk[g]) begin
                    edges_total[g] = edges_total[g] + 1;
                    mosi_cap[g]    = {mosi_cap[g][78:0], spi_mosi[g]};
                    if (last_rise[g] >= 0 && cyc - last_rise[g] != 2 * div_of[g])
                        period_bad[g] = period_bad[g] + 1;
                    last_rise[g] = cyc;
                end
                if (!spi_cs[g] && !spi_clk[g] && prev_clk[g]) begin
                    bit_idx[g] = bit_idx[g] + 1;
                    if (bit_idx[g] < 80) spi_miso[g] = tx[g][79 - bit_idx[g]];
                end
                if (!spi_cs[g] && !prev_cs[g] && spi_mosi[g] != prev_mosi[g]
                    && !(!spi_clk[g] && prev_clk[g]))
                    mosi_bad[g] = mosi_bad[g] + 1;
                if (rsp_valid[g]) begin
                    rsp_total[g] = rsp_total[g] + 1;
                    rsp_last[g]  = rsp_rd_data[g];
                end
                if (cmd_valid[g] && cmd_ready[g]) begin
                    acc_prev[g]  = acc_cyc[g];
                    acc_cyc[g]   = cyc;
                    acc_total[g] = acc_total[g] + 1;
                end
                prev_cs[g]   = spi_cs[g];
                prev_clk[g]  = spi_clk[g];
                prev_mosi[g] = spi_mosi[g];
            end
        end
    end

    function automatic logic [79:0] exp_frame(input logic wr, input logic [31:0] addr,
                                              input logic [31:0] data);
        return wr ? {8'h00, 8'h01, addr, data} : {8'h02, addr, 40'h0};
    endfunction

    function automatic logic [79:0] got_frame(input logic wr, input logic [79:0] f);
        return wr ? {8'h00, f[71:0]} : f;
    endfunction

    task automatic wait_accept(input int g, input int target, output logic ok);
        int n = 0;
        while (acc_total[g] < target && n < 200) begin
            @(posedge up_clk); #1;
            n = n + 1;
        end
        ok = (acc_total[g] >= target);
    endtask

    task automatic wait_idle(input int g, output logic ok);
        int n = 0;
        while (!cmd_ready[g] && n < 3000) begin
            @(posedge up_clk); #1;
            n = n + 1;
        end
        ok = cmd_ready[g];
    endtask

    task automatic run_cmd(input int g, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] rd_pat);
        int e0, c0, r0, a0, d, nb;
        logic [39:0] junk;
        logic ok;
        d  = div_of[g];
        nb = wr ? 72 : 80;
        junk  = {$urandom, 8'($urandom)};
        tx[g] = {junk, 8'hFF, rd_pat};
        e0 = edges_total[g]; c0 = cs_low_total[g]; r0 = rsp_total[g]; a0 = acc_total[g];
        cmd_wr[g] = wr; cmd_addr[g] = addr; cmd_wr_data[g] = data; cmd_valid[g] = 1'b1;
        wait_accept(g, a0 + 1, ok);
        check("accept", 80'(ok), 80'(1));
        cmd_valid[g]   = 1'b0;
        cmd_wr[g]      = ~wr;
        cmd_addr[g]    = $urandom;
        cmd_wr_data[g] = $urandom;
        wait_idle(g, ok);
        check("frame_done", 80'(ok), 80'(1));
        check("edges", 80'(edges_total[g] - e0), 80'(nb));
        check("cs_low", 80'(cs_low_total[g] - c0), 80'(2 * d * nb + d));
        check("rsp_cnt", 80'(rsp_total[g] - r0), 80'(1));
        check("rd_data", 80'(rsp_last[g]), 80'(wr ? 32'h0 : rd_pat));
        check("mosi", got_frame(wr, frame_last[g]), exp_frame(wr, addr, data));
    endtask

    initial begin
        logic ok;
        logic [31:0] a_addr, a_data, b_addr, b_data;
        int a0, r0, e0;
        for (int g = 0; g < 2; g++) begin
            cmd_valid[g] = 1'b0; cmd_wr[g] = 1'b0; cmd_addr[g] = '0; cmd_wr_data[g] = '0;
            tx[g] = '0;
        end
        up_rst = 1'b1;
        repeat (3) @(posedge up_clk);
        #1;
        check("rst_cs", 80'(spi_cs[0]), 80'(1));
        check("rst_clk", 80'(spi_clk[0]), 80'(0));
        check("rst_mosi", 80'(spi_mosi[0]), 80'(0));
        check("rst_ready", 80'(cmd_ready[0]), 80'(1));
        check("rst_busy", 80'(busy[0]), 80'(0));
        check("rst_rsp", 80'(rsp_valid[0]), 80'(0));
        check("rst_rdata", 80'(rsp_rd_data[0]), 80'(0));
        up_rst = 1'b0;
        repeat (2) @(posedge up_clk);
        #1;

        run_cmd(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0);
        run_cmd(0, 1'b0, 32'h0000_0004, 32'h0, 32'h1234_5678);
        run_cmd(1, 1'b1, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 32'h0);
        for (int i = 0; i < 8; i++)
            run_cmd(i % 2, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);

        // cmd_valid held/toggled across a busy frame: only two acceptances, spaced by the full frame.
        a_addr = $urandom; a_data = $urandom; b_addr = $urandom; b_data = $urandom;
        a0 = acc_total[0]; r0 = rsp_total[0];
        cmd_wr[0] = 1'b1; cmd_addr[0] = a_addr; cmd_wr_data[0] = a_data; cmd_valid[0] = 1'b1;
        wait_accept(0, a0 + 1, ok);
        check("b2b_accept1", 80'(ok), 80'(1));
        cmd_addr[0] = b_addr; cmd_wr_data[0] = b_data;
        for (int i = 0; i < 500; i++) begin
            @(posedge up_clk); #1;
            cmd_valid[0] = 1'($urandom_range(0, 1));
        end
        check("b2b_no_early", 80'(acc_total[0] - a0), 80'(1));
        cmd_valid[0] = 1'b1;
        wait_accept(0, a0 + 2, ok);
        cmd_valid[0] = 1'b0;
        check("b2b_accept2", 80'(ok), 80'(1));
        check("b2b_period", 80'(acc_cyc[0] - acc_prev[0]), 80'(1 + 580 + 8));
        wait_idle(0, ok);
        check("b2b_done", 80'(ok), 80'(1));
        check("b2b_acc_cnt", 80'(acc_total[0] - a0), 80'(2));
        check("b2b_rsp_cnt", 80'(rsp_total[0] - r0), 80'(2));
        check("b2b_mosi_a", got_frame(1'b1, frame_prev[0]), exp_frame(1'b1, a_addr, a_data));
        check("b2b_mosi_b", got_frame(1'b1, frame_last[0]), exp_frame(1'b1, b_addr, b_data));

        // Asynchronous reset in the middle of byte 3 of a read.
        tx[0] = {40'h0, 8'hFF, 32'hCAFE_F00D};
        a0 = acc_total[0]; r0 = rsp_total[0];
        cmd_wr[0] = 1'b0; cmd_addr[0] = 32'h0000_0100; cmd_valid[0] = 1'b1;
        wait_accept(0, a0 + 1, ok);
        cmd_valid[0] = 1'b0;
        check("rstmid_accept", 80'(ok), 80'(1));
        e0 = edges_total[0] - 1;
        for (int n = 0; n < 1000 && edges_total[0] - e0 < 28; n++) begin
            @(posedge up_clk); #1;
        end
        check("rstmid_reached", 80'(edges_total[0] - e0 >= 28), 80'(1));
        #2;
        up_rst = 1'b1;
        #1;
        check("rstmid_cs", 80'(spi_cs[0]), 80'(1));
        check("rstmid_clk", 80'(spi_clk[0]), 80'(0));
        check("rstmid_ready", 80'(cmd_ready[0]), 80'(1));
        check("rstmid_busy", 80'(busy[0]), 80'(0));
        repeat (3) @(posedge up_clk);
        #1;
        up_rst = 1'b0;
        repeat (100) @(posedge up_clk);
        #1;
        check("rstmid_no_rsp", 80'(rsp_total[0] - r0), 80'(0));
        run_cmd(0, 1'b1, $urandom, $urandom, 32'h0);
        run_cmd(1, 1'b0, $urandom, 32'h0, $urandom);

        check("clk_period_0", 80'(period_bad[0]), 80'(0));
        check("clk_period_1", 80'(period_bad[1]), 80'(0));
        check("mosi_stable_0", 80'(mosi_bad[0]), 80'(0));
        check("mosi_stable_1", 80'(mosi_bad[1]), 80'(0));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/usbspi_host.md
# usbspi_host

Register-access SPI host that drives the SPI target side of the USB-SPI register bridge. It accepts 32-bit read/write commands on a valid/ready port and serialises each one as a single chip-select frame: command byte, address, then data. It returns read data on a response strobe. Used in simulation benches and on-board self-test to exercise the bridge and the up_* register bus behind it.

## Interface
Parameters:
- CLK_DIV, 4: up_clk cycles per SPI clock half-period; legal range 1..255.
- CS_GAP, 8: minimum up_clk cycles spi_cs stays high between frames; legal range 1..255.

Ports:
- up_clk  input  1  sole clock; all logic rises on posedge.
- up_rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready.
- cmd_wr  input  1  1 = write, 0 = read.
- cmd_addr  input  32  register address.
- cmd_wr_data  input  32  write data; ignored for reads.
- rsp_valid  output  1  one-cycle pulse at frame end, for both reads and writes.
- rsp_rd_data  output  32  read data, valid with rsp_valid; 0 after a write.
- busy  output  1  high from acceptance until the end of the CS gap.
- spi_cs  output  1  chip select, active low.
- spi_clk  output  1  SPI clock, mode 0, idles low.
- spi_mosi  output  1  host-to-target data, MSB first.
- spi_miso  input  1  target-to-host data.

## Operation
- Capture on accept: cmd_wr, cmd_addr and cmd_wr_data are registered when the command is accepted. Later input changes do not affect the frame.
- Write frame (9 bytes, 72 bits): 0x01, addr[31:24], addr[23:16], addr[15:8], addr[7:0], data[31:24] .. data[7:0].
- Read frame (10 bytes, 80 bits): 0x02, the 4 address bytes, 1 dummy byte (MOSI 0x00, MISO ignored), then 4 data bytes. MOSI is 0x00 during the data bytes. The 32 MISO bits are assembled MSB first into rsp_rd_data.
- States:
  - IDLE: cmd_ready = 1; on accept go to SHIFT.
  - SHIFT: runs bits; after the last bit go to HOLD.
  - HOLD: CLK_DIV cycles with spi_clk low and spi_cs low; then go to GAP.
  - GAP: spi_cs high for CS_GAP cycles; then go to IDLE.
- Counters: a half-period divider (0..CLK_DIV-1), a bit counter (7 bits, 0..79) and a gap counter. Frame length is selected from the captured cmd_wr.
- Reset value of every output: spi_cs=1, spi_clk=0, spi_mosi=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_rd_data=0. The FSM returns to IDLE.
- Reset mid-frame: all outputs take their reset values immediately (asynchronous). spi_cs rising aborts the frame at the target. No rsp_valid is produced.
- cmd_valid outside IDLE is ignored. It is not queued.

## Timing
- Acceptance at edge T; at T+1 spi_cs=0 and spi_mosi = bit 7 of byte 0.
- Each bit is 2*CLK_DIV cycles:
  - low half of CLK_DIV cycles, during which spi_mosi is stable;
  - then spi_clk=1 for CLK_DIV cycles.
- spi_mosi changes only on the cycle spi_clk returns to 0. The first low half doubles as CS setup time.
- spi_miso is registered on the last up_clk cycle of each high half.
- spi_cs low duration = 2*CLK_DIV*bits + CLK_DIV cycles:
  - write, CLK_DIV=4: 580 cycles;
  - read, CLK_DIV=4: 644 cycles.
- rsp_valid pulses for exactly one cycle, on the same cycle spi_cs returns to 1. rsp_rd_data is stable from that cycle until the next rsp_valid.
- cmd_ready re-asserts CS_GAP cycles after spi_cs rises. Back-to-back accept-to-accept period = 1 + cs-low duration + CS_GAP.
- CLK_DIV=1: spi_clk = up_clk/2. The same rules apply; there is no zero-length phase.

## Test plan
- Write addr 0x00000010, data 0xDEADBEEF, CLK_DIV=4:
  - MOSI bytes sampled at spi_clk rising edges = 01 00 00 00 10 DE AD BE EF;
  - exactly 72 rising edges; spi_cs low for 580 cycles;
  - one rsp_valid pulse with rsp_rd_data=0.
- Read addr 0x00000004, with a mode-0 target model driving 0x12345678 in bytes 6-9 and 0xFF in the dummy byte:
  - MOSI = 02 00 00 00 04 00 00 00 00 00;
  - 80 rising edges; rsp_rd_data = 0x12345678 with rsp_valid.
- cmd_valid held high for two writes:
  - second acceptance only after spi_cs has been high for CS_GAP=8 cycles;
  - cmd_valid toggled during busy is never accepted.
- up_rst asserted mid-way through byte 3 of a read:
  - spi_cs=1, spi_clk=0, cmd_ready=1 in the same cycle;
  - no rsp_valid;
  - a subsequent write completes normally.
- CLK_DIV=1, CS_GAP=1, write 0xA5A5A5A5 to 0xFFFFFFFF:
  - spi_clk period = 2 cycles;
  - correct MOSI stream; cs-low duration 145 cycles.
